pc_sequencer: RTL and testbench

Next-PC controller for the single-cycle core. Sits in front of the 32-bit program-counter register: observes the current PC, handshakes with instruction memory, arbitrates sequential/branch/jump/trap redirects, and drives the value the PC register loads on every clock edge. It issues only "load" values (`pc_next == pc_cur` means hold), so the PC register needs no enable.

---
 rtl/pc_seq_pkg.sv | 16 +
 rtl/pc_redirect_latch.sv | 27 ++
 rtl/pc_sequencer.sv | 130 +++++++++++++
 tb/tb_pc_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the next-PC sequencer.
// Trap support is enabled by defining PC_SEQ_TRAP_EN.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    WAIT,
    HALTED
  } pc_state_e;

  localparam int          PC_STEP          = 4;
  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VECTOR  = 32'h0000_0080;

endpackage

// File: rtl/pc_redirect_latch.sv
// Single-entry pending redirect: valid bit plus word-aligned target.
// A set while valid overwrites the stored target.
module pc_redirect_latch #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set,
  input  logic             clr,
  input  logic [WIDTH-1:0] addr_in,
  output logic             valid,
  output logic [WIDTH-1:0] addr
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      addr  <= '0;
    end else if (set) begin
      valid <= 1'b1;
      addr  <= addr_in;
    end else if (clr) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller: fetch handshake, redirect arbitration, halt.
// Define PC_SEQ_TRAP_EN to add the trap input and epc output.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEF_RESET_VECTOR),
  parameter logic [WIDTH-1:0] TRAP_VECTOR  = WIDTH'(DEF_TRAP_VECTOR)
) (
  input  logic             clk,
  input  logic             rst,
`ifdef PC_SEQ_TRAP_EN
  input  logic             trap,
  output logic [WIDTH-1:0] epc,
`endif
  input  logic [WIDTH-1:0] pc_cur,
  output logic [WIDTH-1:0] pc_next,
  output logic             imem_req,
  input  logic             imem_ack,
  output logic             fetch_valid,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             halt,
  input  logic             resume
);

  localparam logic [WIDTH-1:0] ALIGN = ~WIDTH'(3);

  pc_state_e        state;
  logic             active;
  logic             redir_vld;
  logic [WIDTH-1:0] redir_addr;
  logic             pend_vld;
  logic [WIDTH-1:0] pend_addr;

  assign active      = (state == FETCH) || (state == WAIT);
  assign fetch_valid = active && imem_ack && !rst;

  // Highest priority is assigned last so it wins.
  always_comb begin
    redir_vld  = 1'b0;
    redir_addr = '0;
    if (branch_taken) begin
      redir_vld  = 1'b1;
      redir_addr = branch_target & ALIGN;
    end
    if (jump) begin
      redir_vld  = 1'b1;
      redir_addr = jump_target & ALIGN;
    end
`ifdef PC_SEQ_TRAP_EN
    if (trap) begin
      redir_vld  = 1'b1;
      redir_addr = TRAP_VECTOR & ALIGN;
    end
`endif
  end

  pc_redirect_latch #(
    .WIDTH(WIDTH)
  ) u_pend (
    .clk    (clk),
    .rst    (rst),
    .set    (active && !imem_ack && redir_vld),
    .clr    (active && imem_ack),
    .addr_in(redir_addr),
    .valid  (pend_vld),
    .addr   (pend_addr)
  );

  always_comb begin
    pc_next = pc_cur;
    if (rst || state == BOOT) begin
      pc_next = RESET_VECTOR;
    end else if (active && imem_ack) begin
      if (redir_vld)
        pc_next = redir_addr;
      else if (pend_vld)
        pc_next = pend_addr;
      else
        pc_next = pc_cur + WIDTH'(PC_STEP);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= BOOT;
      imem_req <= 1'b0;
`ifdef PC_SEQ_TRAP_EN
      epc      <= '0;
`endif
    end else begin
      unique case (state)
        BOOT: begin
          state    <= FETCH;
          imem_req <= 1'b1;
        end
        FETCH, WAIT: begin
          if (!imem_ack) begin
            state    <= WAIT;
            imem_req <= 1'b1;
          end else if (halt) begin
            state    <= HALTED;
            imem_req <= 1'b0;
          end else begin
            state    <= FETCH;
            imem_req <= 1'b1;
          end
`ifdef PC_SEQ_TRAP_EN
          if (trap)
            epc <= pc_cur;
`endif
        end
        HALTED: begin
          if (resume && !halt) begin
            state    <= FETCH;
            imem_req <= 1'b1;
          end
        end
        default: begin
          state    <= BOOT;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed test of pc_sequencer with a behavioural PC register.
// Trap scenario runs when PC_SEQ_TRAP_EN is defined.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_cur;
  logic [31:0] pc_next;
  logic        imem_req;
  logic        imem_ack;
  logic        fetch_valid;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        halt;
  logic        resume;
`ifdef PC_SEQ_TRAP_EN
  logic        trap;
  logic [31:0] epc;
`endif

  logic        pc_ld;
  logic [31:0] pc_ld_val;
  int          n_pass = 0;
  int          n_total = 0;

  always #5 clk = ~clk;

  // PC register; the bench may force-load it to reach a given address.
  always @(posedge clk)
    pc_cur <= pc_ld ? pc_ld_val : pc_next;

  pc_sequencer #(
    .WIDTH       (32),
    .RESET_VECTOR(32'h0000_0100),
    .TRAP_VECTOR (32'h0000_0080)
  ) dut (
    .clk          (clk),
    .rst          (rst),
`ifdef PC_SEQ_TRAP_EN
    .trap         (trap),
    .epc          (epc),
`endif
    .pc_cur       (pc_cur),
    .pc_next      (pc_next),
    .imem_req     (imem_req),
    .imem_ack     (imem_ack),
    .fetch_valid  (fetch_valid),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .jump         (jump),
    .jump_target  (jump_target),
    .halt         (halt),
    .resume       (resume)
  );

  task automatic load_pc(input logic [31:0] v);
    @(negedge clk);
    pc_ld     = 1'b1;
    pc_ld_val = v;
    @(negedge clk);
    pc_ld     = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    imem_ack = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    n_total++;
    if (pc_next !== 32'h100)
      $display("FAIL reset_pc_next: got %h want %h", pc_next, 32'h100);
    else n_pass++;
    n_total++;
    if (imem_req !== 1'b0)
      $display("FAIL reset_req: got %b want 0", imem_req);
    else n_pass++;
    n_total++;
    if (fetch_valid !== 1'b0)
      $display("FAIL reset_fv: got %b want 0", fetch_valid);
    else n_pass++;
  endtask

  task automatic test_sequential;
    rst = 1'b0;
    #1;
    n_total++;
    if (imem_req !== 1'b0)
      $display("FAIL boot_req: got %b want 0", imem_req);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      n_total++;
      if (pc_cur !== 32'h100 + 32'(4 * i) || imem_req !== 1'b1 ||
          fetch_valid !== 1'b1 || pc_next !== 32'h104 + 32'(4 * i))
        $display("FAIL seq_%0d: got pc=%h req=%b fv=%b nxt=%h want pc=%h nxt=%h",
                 i, pc_cur, imem_req, fetch_valid, pc_next,
                 32'h100 + 32'(4 * i), 32'h104 + 32'(4 * i));
      else n_pass++;
    end
  endtask

  task automatic test_wait_redirect;
    load_pc(32'h104);
    imem_ack      = 1'b0;
    branch_taken  = 1'b1;
    branch_target = 32'h200;
    #1;
    n_total++;
    if (pc_next !== 32'h104 || fetch_valid !== 1'b0 || imem_req !== 1'b1)
      $display("FAIL wait1: got nxt=%h fv=%b req=%b want 104 0 1",
               pc_next, fetch_valid, imem_req);
    else n_pass++;
    @(negedge clk);
    branch_taken = 1'b0;
    jump         = 1'b1;
    jump_target  = 32'h300;
    #1;
    n_total++;
    if (pc_cur !== 32'h104 || pc_next !== 32'h104)
      $display("FAIL wait2: got pc=%h nxt=%h want 104 104", pc_cur, pc_next);
    else n_pass++;
    @(negedge clk);
    jump = 1'b0;
    #1;
    n_total++;
    if (pc_next !== 32'h104)
      $display("FAIL wait3: got nxt=%h want 104", pc_next);
    else n_pass++;
    @(negedge clk);
    imem_ack = 1'b1;
    #1;
    n_total++;
    if (pc_next !== 32'h300 || fetch_valid !== 1'b1)
      $display("FAIL wait_ack: got nxt=%h fv=%b want 300 1",
               pc_next, fetch_valid);
    else n_pass++;
    @(negedge clk);
    #1;
    n_total++;
    if (pc_cur !== 32'h300 || pc_next !== 32'h304)
      $display("FAIL pend_clear: got pc=%h nxt=%h want 300 304",
               pc_cur, pc_next);
    else n_pass++;
  endtask

  task automatic test_priority;
    @(negedge clk);
    imem_ack      = 1'b1;
    jump          = 1'b1;
    jump_target   = 32'h400;
    branch_taken  = 1'b1;
    branch_target = 32'h503;
    #1;
    n_total++;
    if (pc_next !== 32'h400)
      $display("FAIL prio_jump: got %h want %h", pc_next, 32'h400);
    else n_pass++;
    jump = 1'b0;
    #1;
    n_total++;
    if (pc_next !== 32'h500)
      $display("FAIL branch_align: got %h want %h", pc_next, 32'h500);
    else n_pass++;
    @(negedge clk);
    branch_taken = 1'b0;
    #1;
    n_total++;
    if (pc_cur !== 32'h500)
      $display("FAIL branch_load: got %h want %h", pc_cur, 32'h500);
    else n_pass++;
  endtask

  task automatic test_wrap;
    load_pc(32'hFFFF_FFFC);
    n_total++;
    if (pc_next !== 32'h0)
      $display("FAIL wrap_next: got %h want 0", pc_next);
    else n_pass++;
    @(negedge clk);
    #1;
    n_total++;
    if (pc_cur !== 32'h0 || pc_next !== 32'h4)
      $display("FAIL wrap_pc: got pc=%h nxt=%h want 0 4", pc_cur, pc_next);
    else n_pass++;
  endtask

  task automatic test_halt;
    load_pc(32'h20);
    halt = 1'b1;
    #1;
    n_total++;
    if (pc_next !== 32'h24 || fetch_valid !== 1'b1)
      $display("FAIL halt_ack: got nxt=%h fv=%b want 24 1",
               pc_next, fetch_valid);
    else n_pass++;
    @(negedge clk);
    halt        = 1'b0;
    jump        = 1'b1;
    jump_target = 32'h600;
    #1;
    n_total++;
    if (pc_cur !== 32'h24 || imem_req !== 1'b0 || fetch_valid !== 1'b0 ||
        pc_next !== 32'h24)
      $display("FAIL halted: got pc=%h req=%b fv=%b nxt=%h want 24 0 0 24",
               pc_cur, imem_req, fetch_valid, pc_next);
    else n_pass++;
    jump   = 1'b0;
    halt   = 1'b1;
    resume = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    #1;
    n_total++;
    if (imem_req !== 1'b0 || pc_cur !== 32'h24)
      $display("FAIL halt_resume_both: got req=%b pc=%h want 0 24",
               imem_req, pc_cur);
    else n_pass++;
    @(negedge clk);
    resume = 1'b0;
    #1;
    n_total++;
    if (imem_req !== 1'b1 || pc_cur !== 32'h24 || pc_next !== 32'h28)
      $display("FAIL resume: got req=%b pc=%h nxt=%h want 1 24 28",
               imem_req, pc_cur, pc_next);
    else n_pass++;
  endtask

  task automatic test_rst_mid_wait;
    @(negedge clk);
    imem_ack      = 1'b0;
    branch_taken  = 1'b1;
    branch_target = 32'h700;
    @(negedge clk);
    branch_taken = 1'b0;
    rst          = 1'b1;
    #1;
    n_total++;
    if (pc_next !== 32'h100)
      $display("FAIL rst_wait_next: got %h want %h", pc_next, 32'h100);
    else n_pass++;
    @(negedge clk);
    rst      = 1'b0;
    imem_ack = 1'b1;
    #1;
    n_total++;
    if (imem_req !== 1'b0 || fetch_valid !== 1'b0 || pc_next !== 32'h100)
      $display("FAIL rst_boot: got req=%b fv=%b nxt=%h want 0 0 100",
               imem_req, fetch_valid, pc_next);
    else n_pass++;
    @(negedge clk);
    #1;
    n_total++;
    if (pc_cur !== 32'h100 || pc_next !== 32'h104)
      $display("FAIL rst_pend_drop: got pc=%h nxt=%h want 100 104",
               pc_cur, pc_next);
    else n_pass++;
  endtask

`ifdef PC_SEQ_TRAP_EN
  task automatic test_trap;
    load_pc(32'h40);
    trap        = 1'b1;
    jump        = 1'b1;
    jump_target = 32'h300;
    #1;
    n_total++;
    if (pc_next !== 32'h80)
      $display("FAIL trap_next: got %h want %h", pc_next, 32'h80);
    else n_pass++;
    @(negedge clk);
    trap = 1'b0;
    jump = 1'b0;
    #1;
    n_total++;
    if (epc !== 32'h40 || pc_cur !== 32'h80)
      $display("FAIL trap_epc: got epc=%h pc=%h want 40 80", epc, pc_cur);
    else n_pass++;
  endtask
`endif

  initial begin
    rst           = 1'b1;
    imem_ack      = 1'b1;
    branch_taken  = 1'b0;
    branch_target = '0;
    jump          = 1'b0;
    jump_target   = '0;
    halt          = 1'b0;
    resume        = 1'b0;
    pc_ld         = 1'b0;
    pc_ld_val     = '0;
`ifdef PC_SEQ_TRAP_EN
    trap          = 1'b0;
`endif
    test_reset();
    test_sequential();
    test_wait_redirect();
    test_priority();
    test_wrap();
    test_halt();
    test_rst_mid_wait();
`ifdef PC_SEQ_TRAP_EN
    test_trap();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
